id_ex_stage: RTL

- ID/EX pipeline register plus operand-forwarding network for the RV32I 5-stage core.
- Latches decoded instruction fields on each unstalled cycle and resolves RAW hazards against the MEM and WB stages.
- Drives the ALU's A, B and ALUSel inputs, and forwards the control and store data toward EX/MEM.

---
 rtl/riscv_pkg.sv | 48 ++++
 rtl/fwd_mux.sv | 43 ++++
 rtl/id_ex_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: ALU opcodes, writeback/forward selects
// and the ID/EX register payload.
package riscv_pkg;

  localparam int RV_XLEN   = 32;
  localparam int RV_REG_AW = 5;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wbsel_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic [RV_XLEN-1:0]   pc;
    logic [RV_XLEN-1:0]   rs1_data;
    logic [RV_XLEN-1:0]   rs2_data;
    logic [RV_XLEN-1:0]   imm;
    logic [RV_REG_AW-1:0] rs1;
    logic [RV_REG_AW-1:0] rs2;
    logic [RV_REG_AW-1:0] rd;
    logic [3:0]           alusel;
    logic                 asel;
    logic                 bsel;
    logic                 regwen;
    logic                 memrw;
    wbsel_t               wbsel;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding for one source register: picks MEM result, WB result
// or the registered regfile data, youngest writer first.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int XLEN   = RV_XLEN,
  parameter int REG_AW = RV_REG_AW
) (
  input  logic [REG_AW-1:0] src_idx,
  input  logic [XLEN-1:0]   reg_data,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwen,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwen,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   fwd_data
);

  fwd_sel_t sel;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    sel = FWD_REG;
    if (src_idx != '0) begin
      if (mem_regwen && (mem_rd == src_idx)) begin
        sel = FWD_MEM;
      end else if (wb_regwen && (wb_rd == src_idx)) begin
        sel = FWD_WB;
      end
    end
  end

  always_comb begin
    fwd_data = reg_data;
    case (sel)
      FWD_MEM: fwd_data = mem_result;
      FWD_WB:  fwd_data = wb_result;
      default: fwd_data = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU operand selection. Forwarding from MEM/WB
// is built only when ID_EX_FWD_EN is defined; otherwise operands come raw from the regfile.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = RV_XLEN,
  parameter int REG_AW = RV_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [3:0]        id_alusel,
  input  logic              id_asel,
  input  logic              id_bsel,
  input  logic              id_regwen,
  input  logic              id_memrw,
  input  logic [1:0]        id_wbsel,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwen,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwen,
  input  logic [XLEN-1:0]   wb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [3:0]        alu_sel,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regwen,
  output logic              ex_memrw,
  output logic [1:0]        ex_wbsel
);

  id_ex_t id_fields;
  id_ex_t id_ex_d;
  id_ex_t id_ex_q;

  always_comb begin
    id_fields          = '0;
    id_fields.valid    = id_valid;
    id_fields.pc       = id_pc;
    id_fields.rs1_data = id_rs1_data;
    id_fields.rs2_data = id_rs2_data;
    id_fields.imm      = id_imm;
    id_fields.rs1      = id_rs1;
    id_fields.rs2      = id_rs2;
    id_fields.rd       = id_rd;
    id_fields.alusel   = id_alusel;
    id_fields.asel     = id_asel;
    id_fields.bsel     = id_bsel;
    id_fields.regwen   = id_regwen;
    id_fields.memrw    = id_memrw;
    id_fields.wbsel    = wbsel_t'(id_wbsel);
  end

  // Flush outranks stall so a squashed instruction never lingers in EX.
  always_comb begin
    id_ex_d = id_ex_q;
    if (flush) begin
      id_ex_d = '0;
    end else if (!stall) begin
      id_ex_d = id_fields;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

`ifdef ID_EX_FWD_EN
  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .src_idx    (id_ex_q.rs1),
    .reg_data   (id_ex_q.rs1_data),
    .mem_rd     (mem_rd),
    .mem_regwen (mem_regwen),
    .mem_result (mem_result),
    .wb_rd      (wb_rd),
    .wb_regwen  (wb_regwen),
    .wb_result  (wb_result),
    .fwd_data   (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .src_idx    (id_ex_q.rs2),
    .reg_data   (id_ex_q.rs2_data),
    .mem_rd     (mem_rd),
    .mem_regwen (mem_regwen),
    .mem_result (mem_result),
    .wb_rd      (wb_rd),
    .wb_regwen  (wb_regwen),
    .wb_result  (wb_result),
    .fwd_data   (fwd_rs2)
  );
`else
  // Without forwarding the hazard unit stalls on every RAW dependency.
  assign fwd_rs1 = id_ex_q.rs1_data;
  assign fwd_rs2 = id_ex_q.rs2_data;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mem_rd, mem_regwen, mem_result,
                               wb_rd, wb_regwen, wb_result,
                               id_ex_q.rs1, id_ex_q.rs2};
`endif

  assign alu_a         = id_ex_q.asel ? id_ex_q.pc  : fwd_rs1;
  assign alu_b         = id_ex_q.bsel ? id_ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;

  assign ex_valid  = id_ex_q.valid;
  assign alu_sel   = id_ex_q.alusel;
  assign ex_pc     = id_ex_q.pc;
  assign ex_imm    = id_ex_q.imm;
  assign ex_rd     = id_ex_q.rd;
  assign ex_regwen = id_ex_q.regwen;
  assign ex_memrw  = id_ex_q.memrw;
  assign ex_wbsel  = id_ex_q.wbsel;

endmodule
